// File: rtl/fetch_queue_if.sv
// Bundle of the fetch queue's external signals: the instruction-memory
// request/response port, the redirect input and the IF/ID output port.
// The master modport is the fetch queue itself; the slave modport is the
// environment (instruction memory, branch unit and IF/ID stage).
//
// Handshakes:
//   imem_req/imem_gnt : a request transfers on a rising edge where both are 1;
//                       imem_addr is stable while imem_req=1 and imem_gnt=0.
//   imem_rvalid       : single-cycle response strobe, no back-pressure;
//                       responses return in request order.
//   out_valid/out_ready : the head entry transfers on a rising edge where both
//                       are 1; a redirect in that cycle cancels the transfer.
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic        out_ready;
    logic        proto_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output out_valid, out_instr, out_pc4,
        input  out_ready,
        output proto_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  out_valid, out_instr, out_pc4,
        output out_ready,
        input  proto_err
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding the IF/ID register. Issues sequential
// fetches under a credit limit of DEPTH (queued + outstanding + discarded),
// tags each request with its address, buffers responses in order, and on a
// redirect flushes the queue and discards responses still in flight.
// Optional macro FETCH_QUEUE_BYPASS_EN: a response arriving at an empty queue
// is presented on out_* in the same cycle.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_queue_if.master          bus,
    output logic                   dbg_state,
    output logic [$clog2(DEPTH):0] dbg_count,
    output logic [$clog2(DEPTH):0] dbg_outstanding,
    output logic [$clog2(DEPTH):0] dbg_discard
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic          proto_err_q, proto_err_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];
    logic [31:0]   pc4_mem_q   [DEPTH];
    logic [31:0]   pc4_mem_d   [DEPTH];
    logic [31:0]   tag_mem_q   [DEPTH];
    logic [31:0]   tag_mem_d   [DEPTH];

    logic [CW:0]   credits_used;
    logic          req, grant, rv_known, rsp_hit, fifo_valid, push, pop, bypass;
    logic [31:0]   tag_pc4;

    // Low address bits of a redirect target are dropped by design.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^bus.redirect_pc[1:0];

    // Outputs, credit check, response routing and next state.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        tag_rd_d      = tag_rd_q;
        tag_wr_d      = tag_wr_q;
        proto_err_d   = proto_err_q;
        instr_mem_d   = instr_mem_q;
        pc4_mem_d     = pc4_mem_q;
        tag_mem_d     = tag_mem_q;

        credits_used = {1'b0, count_q} + {1'b0, outstanding_q} + {1'b0, discard_q};
        req          = rst && !bus.redirect && (credits_used < DEPTH_C);
        grant        = req && bus.imem_gnt;
        // A response is legitimate only if something is owed to us.
        rv_known     = bus.imem_rvalid && ((outstanding_q != '0) || (discard_q != '0));
        // Responses that belong to the current fetch stream.
        rsp_hit      = bus.imem_rvalid && !bus.redirect && (state_q == RUN) &&
                       (outstanding_q != '0);
        tag_pc4      = tag_mem_q[tag_rd_q] + 32'd4;
        fifo_valid   = (count_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
        bypass        = rsp_hit && !fifo_valid;
        bus.out_valid = fifo_valid || bypass;
        bus.out_instr = bypass ? bus.imem_rdata : instr_mem_q[rd_ptr_q];
        bus.out_pc4   = bypass ? tag_pc4 : pc4_mem_q[rd_ptr_q];
        push          = rsp_hit && !(bypass && bus.out_ready);
`else
        bypass        = 1'b0;
        bus.out_valid = fifo_valid;
        bus.out_instr = instr_mem_q[rd_ptr_q];
        bus.out_pc4   = pc4_mem_q[rd_ptr_q];
        push          = rsp_hit;
`endif
        pop           = fifo_valid && bus.out_ready && !bus.redirect;
        bus.imem_req  = req;
        bus.imem_addr = fetch_pc_q;
        bus.proto_err = proto_err_q;

        if (bus.imem_rvalid && !rv_known) begin
            proto_err_d = 1'b1;
        end

        if (bus.redirect) begin
            // Flush everything queued; whatever is still in flight becomes discard.
            fetch_pc_d    = {bus.redirect_pc[31:2], 2'b00};
            rd_ptr_d      = wr_ptr_q;
            count_d       = '0;
            tag_rd_d      = tag_wr_q;
            outstanding_d = '0;
            discard_d     = discard_q + outstanding_q - (rv_known ? CNT_ONE : '0);
            state_d       = (discard_d != '0) ? DRAIN : RUN;
        end else begin
            if (grant) begin
                fetch_pc_d          = fetch_pc_q + 32'd4;
                tag_mem_d[tag_wr_q] = fetch_pc_q;
                tag_wr_d            = tag_wr_q + PTR_ONE;
            end
            if (rsp_hit) begin
                tag_rd_d = tag_rd_q + PTR_ONE;
            end
            outstanding_d = outstanding_q + CW'(grant) - CW'(rsp_hit);
            if (push) begin
                instr_mem_d[wr_ptr_q] = bus.imem_rdata;
                pc4_mem_d[wr_ptr_q]   = tag_pc4;
                wr_ptr_d              = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            count_d = count_q + CW'(push) - CW'(pop);
            // Stale responses from before a redirect are counted off and dropped.
            if ((state_q == DRAIN) && bus.imem_rvalid && (discard_q != '0)) begin
                discard_d = discard_q - CNT_ONE;
                if (discard_d == '0) begin
                    state_d = RUN;
                end
            end
        end
    end

    // State, counters, pointers and storage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
            proto_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc4_mem_q[i]   <= '0;
                tag_mem_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
            proto_err_q   <= proto_err_d;
            instr_mem_q   <= instr_mem_d;
            pc4_mem_q     <= pc4_mem_d;
            tag_mem_q     <= tag_mem_d;
        end
    end

    assign dbg_state       = (state_q == DRAIN);
    assign dbg_count       = count_q;
    assign dbg_outstanding = outstanding_q;
    assign dbg_discard     = discard_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a random-latency instruction memory, random grants,
// stalls and redirects. The reference is the program-order stream: every
// grant in the current fetch stream adds {instr, addr+4} to exp_q, a redirect
// starts a new stream, and a monitor pops exp_q whenever IF/ID takes an entry.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dbg_state;
    logic [2:0] dbg_count, dbg_outstanding, dbg_discard;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .dbg_state       (dbg_state),
        .dbg_count       (dbg_count),
        .dbg_outstanding (dbg_outstanding),
        .dbg_discard     (dbg_discard)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
        int          due;
    } mem_t;

    logic [63:0] exp_q[$];   // {instr, pc4} in program order for the current stream
    mem_t        mem_q[$];   // requests accepted by the memory, not yet answered
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          cur_epoch = 0;
    int          n_ret = 0;  // current-stream responses returned but not consumed
    int          p_gnt, p_rv, p_rdy, p_redir;
    logic [31:0] model_pc;
    bit          rsp_prev, redir_prev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int stale_cnt();
        int n = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != cur_epoch) n++;
        return n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst             = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b0;
        mem_q.delete();
        exp_q.delete();
        cur_epoch  = 0;
        n_ret      = 0;
        model_pc   = RESET_PC;
        rsp_prev   = 1'b0;
        redir_prev = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_imem_req", bus.imem_req, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_instr", bus.out_instr, 0);
        check("rst_out_pc4", bus.out_pc4, 0);
        check("rst_proto_err", bus.proto_err, 0);
        check("rst_imem_addr", bus.imem_addr, RESET_PC);
        rst = 1'b1;
    endtask

    task automatic drive_cycle();
        bit          do_redir, do_rv, cur_rsp, exp_req;
        int          stale;
        mem_t        m;
        logic [31:0] d;
        @(negedge clk);
        cyc++;
        do_redir        = ($urandom_range(99) < p_redir);
        bus.redirect    = do_redir;
        bus.redirect_pc = $urandom;
        do_rv           = (mem_q.size() > 0) && (mem_q[0].due <= cyc) &&
                          ($urandom_range(99) < p_rv);
        bus.imem_rvalid = do_rv;
        bus.imem_rdata  = do_rv ? mem_q[0].data : $urandom;
        bus.imem_gnt    = ($urandom_range(99) < p_gnt);
        bus.out_ready   = ($urandom_range(99) < p_rdy);
        #1;
        stale   = stale_cnt();
        exp_req = !do_redir && ((exp_q.size() + stale) < DEPTH);
        check("imem_req", bus.imem_req, exp_req);
        if (exp_req) check("imem_addr", bus.imem_addr, model_pc);
        check("discard", dbg_discard, stale);
        check("drain_state", dbg_state, stale != 0);
        check("proto_err", bus.proto_err, 0);
        if (redir_prev) check("out_valid_after_redirect", bus.out_valid, 0);
`ifndef FETCH_QUEUE_BYPASS_EN
        if (rsp_prev) check("out_valid_latency", bus.out_valid, 1);
`endif
        cur_rsp = 1'b0;
        if (do_rv) begin
            m       = mem_q.pop_front();
            cur_rsp = (m.epoch == cur_epoch) && !do_redir;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (cur_rsp && n_ret == 0) begin
            check("bypass_valid", bus.out_valid, 1);
            check("bypass_instr", bus.out_instr, m.data);
            check("bypass_pc4", bus.out_pc4, m.addr + 32'd4);
        end
`endif
        if (cur_rsp) n_ret++;
        rsp_prev   = cur_rsp;
        redir_prev = do_redir;
        if (do_redir) begin
            cur_epoch++;
            exp_q.delete();
            n_ret    = 0;
            model_pc = {bus.redirect_pc[31:2], 2'b00};
        end else if (exp_req && bus.imem_gnt) begin
            d = $urandom;
            exp_q.push_back({d, model_pc + 32'd4});
            mem_q.push_back('{addr: model_pc, data: d, epoch: cur_epoch, due: cyc + 1});
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic run(input int n, input int g, input int rv, input int rd, input int rr);
        p_gnt   = g;
        p_rv    = rv;
        p_rdy   = rd;
        p_redir = rr;
        repeat (n) drive_cycle();
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && bus.out_valid && bus.out_ready && !bus.redirect) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got pc4 %h, expected no entry (cycle %0d)",
                             bus.out_pc4, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_instr", bus.out_instr, e[63:32]);
                    check("out_pc4", bus.out_pc4, e[31:0]);
                    n_ret--;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        do_reset();
        // Sequential stream, memory answers immediately, no stalls.
        run(20, 100, 100, 100, 0);
        // IF/ID stalled: credits run out after DEPTH entries.
        run(20, 100, 100, 0, 0);
        check("full_count", dbg_count, DEPTH);
        check("full_valid", bus.out_valid, 1);
        check("full_head_pc4", bus.out_pc4, exp_q[0][31:0]);
        // Release the stall.
        run(20, 100, 100, 100, 0);
        // Random traffic with occasional and then frequent redirects.
        run(3000, 60, 50, 70, 5);
        run(1000, 80, 60, 80, 20);
        // Drain: no new grants, everything outstanding returns and is consumed.
        run(40, 0, 100, 100, 0);
        check("drain_exp_empty", exp_q.size(), 0);
        check("drain_mem_empty", mem_q.size(), 0);
        check("drain_count", dbg_count, 0);
        check("drain_outstanding", dbg_outstanding, 0);

        // Reset with requests in flight, then a stray response.
        do_reset();
        run(3, 100, 0, 0, 0);
        do_reset();
        @(negedge clk);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = $urandom;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        #1;
        check("proto_err_set", bus.proto_err, 1);
        repeat (4) @(negedge clk);
        #1;
        check("proto_err_sticky", bus.proto_err, 1);
        rst = 1'b0;
        #1;
        check("proto_err_cleared", bus.proto_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
